// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter on a single clock (clk).
// The bus side pushes bytes into a 2**FIFO_AW deep FIFO. An FSM pops the
// bytes and sends them on txd as 8N1 frames, timed by an internal baud
// divider of CLK_DIV clk cycles per bit.
//
// Optional build macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is sent after the data bits and the frame becomes 8E1 (11 bit times).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     push request
//   wr_data   byte to push
//   full      FIFO holds 2**FIFO_AW entries (registered)
//   overflow  one-cycle pulse: a push was dropped because the FIFO was full
//   level     FIFO occupancy (registered)
//   idle      registered (state == IDLE && level == 0)
//   txd       serial output, registered, idles high
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte back-to-back if one is queued
module uart_tx_fifo #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               overflow,
    output logic [FIFO_AW:0]   level,
    output logic               idle,
    output logic               txd
);

    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] ONE_L   = (FIFO_AW+1)'(1);
    localparam logic [15:0]     BAUD_TC = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_nxt;
    logic               push, pop;

    state_t      state_q, state_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic [2:0]  bit_q, bit_nxt;
    logic [7:0]  shift_q;
    logic        txd_nxt;
    logic        baud_end;

    // Full is judged on the pre-edge value, so a push at a full FIFO is
    // dropped even if the FSM pops at the same edge.
    assign push     = wr_en && !full;
    assign baud_end = (cnt_q == BAUD_TC);

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + ONE_L;
        else if (pop && !push)
            level_nxt = level - ONE_L;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level    <= level_nxt;
            full     <= (level_nxt == DEPTH_L);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd     <= 1'b1;
            idle    <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            bit_q   <= bit_nxt;
            if (pop)
                shift_q <= mem[rd_ptr];
            txd     <= txd_nxt;
            idle    <= (state_q == S_IDLE) && (level == '0);
        end
    end

    // txd is the registered image of the current state, so the line follows
    // a state change one cycle later; every bit still lasts CLK_DIV cycles.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = baud_end ? 16'd0 : cnt_q + 16'd1;
        bit_nxt   = bit_q;
        pop       = 1'b0;
        txd_nxt   = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_nxt = '0;
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                txd_nxt = 1'b0;
                if (baud_end) begin
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                txd_nxt = shift_q[bit_q];
                if (baud_end) begin
                    bit_nxt = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_nxt = ^shift_q;
                if (baud_end)
                    state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                txd_nxt = 1'b1;
                if (baud_end) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int D4 = 4;
    localparam int DB = 20;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * D4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en4 = 1'b0, wr_en_b = 1'b0;
    logic [7:0] wr_data4 = '0, wr_data_b = '0;
    logic       full4, overflow4, idle4, txd4;
    logic       full_b, overflow_b, idle_b, txd_b;
    logic [4:0] level4, level_b;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLK_DIV(D4), .FIFO_AW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en4), .wr_data(wr_data4),
        .full(full4), .overflow(overflow4), .level(level4), .idle(idle4), .txd(txd4)
    );

    uart_tx_fifo #(.CLK_DIV(DB), .FIFO_AW(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .full(full_b), .overflow(overflow_b), .level(level_b), .idle(idle_b), .txd(txd_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying byte b.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9)
            return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered on the first negedge where txd4 is low; checks n frames cycle by cycle.
    task automatic check_frames(input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] by;
        for (int j = 0; j < n * FL; j++) begin
            by = (j < FL) ? b0 : b1;
            chk("txd4", 32'(txd4), 32'(fbit(by, (j % FL) / D4)));
            if (j == FL - 2)
                chk("level_mid", 32'(level4), (n == 2) ? 32'd1 : 32'd0);
            if (j == n * FL - 1)
                chk("idle_late", 32'(idle4), 32'd0);
            @(negedge clk);
        end
        chk("idle_end", 32'(idle4), 32'd1);
        chk("level_end", 32'(level4), 32'd0);
    endtask

    // Receiver for the slow instance: samples each bit at its centre.
    logic [7:0] rxq[$];
    logic [7:0] rx_byte;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !txd_b) begin
                repeat (DB / 2) @(negedge clk);
                chk("b_start", 32'(txd_b), 32'd0);
                for (int k = 1; k < NB; k++) begin
                    repeat (DB) @(negedge clk);
                    if (k <= 8)
                        rx_byte[k-1] = txd_b;
`ifdef UART_TX_PARITY_EN
                    else if (k == 9)
                        chk("b_parity", 32'(txd_b), 32'(^rx_byte));
`endif
                    else
                        chk("b_stop", 32'(txd_b), 32'd1);
                end
                rxq.push_back(rx_byte);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int t;
    int lows;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_txd", 32'(txd4), 32'd1);
        chk("rst_full", 32'(full4), 32'd0);
        chk("rst_ovf", 32'(overflow4), 32'd0);
        chk("rst_level", 32'(level4), 32'd0);
        chk("rst_idle", 32'(idle4), 32'd1);
        chk("rst_txd_b", 32'(txd_b), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single 0x55 frame: latency and bit pattern
        wr_en4 = 1'b1; wr_data4 = 8'h55;
        @(negedge clk);
        wr_en4 = 1'b0;
        chk("lat_level_n", 32'(level4), 32'd1);
        chk("lat_idle_n", 32'(idle4), 32'd1);
        chk("lat_txd_n", 32'(txd4), 32'd1);
        @(negedge clk);
        chk("lat_level_n1", 32'(level4), 32'd0);
        chk("lat_idle_n1", 32'(idle4), 32'd0);
        chk("lat_txd_n1", 32'(txd4), 32'd1);
        @(negedge clk);
        check_frames(1, 8'h55, 8'h00);
        repeat (3) @(negedge clk);

        // two back-to-back frames: 0xA5 then 0x3C
        wr_en4 = 1'b1; wr_data4 = 8'hA5;
        @(negedge clk);
        chk("two_level_n", 32'(level4), 32'd1);
        wr_data4 = 8'h3C;
        @(negedge clk);
        wr_en4 = 1'b0;
        chk("two_level_n1", 32'(level4), 32'd1);
        @(negedge clk);
        check_frames(2, 8'hA5, 8'h3C);
        repeat (3) @(negedge clk);

        // parity-sensitive bytes 0x07, 0x03
        wr_en4 = 1'b1; wr_data4 = 8'h07;
        @(negedge clk);
        wr_data4 = 8'h03;
        @(negedge clk);
        wr_en4 = 1'b0;
        @(negedge clk);
        check_frames(2, 8'h07, 8'h03);
        repeat (3) @(negedge clk);

        // fill, overflow and push-during-pop on the slow instance
        wr_en_b = 1'b1; wr_data_b = 8'hFF;
        @(negedge clk);
        wr_en_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_level0", 32'(level_b), 32'd0);
        for (int i = 0; i < 17; i++) begin
            wr_en_b = 1'b1; wr_data_b = 8'(i);
            @(negedge clk);
            if (i == 14)
                chk("b_full15", 32'(full_b), 32'd0);
            if (i == 15) begin
                chk("b_full16", 32'(full_b), 32'd1);
                chk("b_level16", 32'(level_b), 32'd16);
                chk("b_ovf16", 32'(overflow_b), 32'd0);
            end
            if (i == 16) begin
                chk("b_ovf17", 32'(overflow_b), 32'd1);
                chk("b_level17", 32'(level_b), 32'd16);
            end
        end
        wr_en_b = 1'b0;
        @(negedge clk);
        chk("b_ovf_pulse", 32'(overflow_b), 32'd0);
        chk("b_level_hold", 32'(level_b), 32'd16);

        wr_en_b = 1'b1; wr_data_b = 8'hEE;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (level_b == 5'd16 && t < 300);
        wr_en_b = 1'b0;
        chk("pp_level", 32'(level_b), 32'd15);
        chk("pp_ovf", 32'(overflow_b), 32'd1);
        chk("pp_full", 32'(full_b), 32'd0);

        t = 0;
        while (rxq.size() < 17 && t < 17 * NB * DB + 500) begin
            @(negedge clk);
            t++;
        end
        chk("rx_count", 32'(rxq.size()), 32'd17);
        for (int i = 0; i < 17; i++)
            chk("rx_byte", (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD,
                (i == 0) ? 32'hFF : 32'(i - 1));
        t = 0;
        while (!idle_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("b_idle_end", 32'(idle_b), 32'd1);
        chk("b_level_end", 32'(level_b), 32'd0);

        // reset in the middle of the data bits of 0xFF with 3 bytes queued
        wr_en4 = 1'b1; wr_data4 = 8'hFF;
        @(negedge clk);
        wr_data4 = 8'h11;
        @(negedge clk);
        wr_data4 = 8'h22;
        @(negedge clk);
        wr_data4 = 8'h33;
        @(negedge clk);
        wr_en4 = 1'b0;
        chk("mr_level3", 32'(level4), 32'd3);
        chk("mr_start", 32'(txd4), 32'd0);
        repeat (3 * D4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_txd", 32'(txd4), 32'd1);
        chk("mr_level", 32'(level4), 32'd0);
        chk("mr_full", 32'(full4), 32'd0);
        chk("mr_idle", 32'(idle4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_idle_rel", 32'(idle4), 32'd1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!txd4)
                lows++;
        end
        chk("mr_no_frame", 32'(lows), 32'd0);
        chk("mr_level_end", 32'(level4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
